// File: rtl/csa_stream_accumulator.sv
// Purpose: sums a packet of unsigned operands. The running total stays in carry-save (sum/carry)
//          form while operands arrive, then a chunked carry-propagate pass resolves it into one result.
// Ports:   clk/rst_n (async active-low); in_valid/in_ready/in_data/in_last for the operand stream;
//          out_valid/out_ready/out_sum/out_ovf for the result; busy is high whenever the state is not IDLE.
module csa_stream_accumulator #(
  parameter int WIDTH = 4,
  parameter int ACC_W = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf,
  output logic             busy
);

  localparam int N     = ACC_W / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

  state_t             state;
  logic [ACC_W-1:0]   s, c, res;
  logic [CNT_W-1:0]   cnt;
  logic               cy;
  logic               ovf;

  logic [ACC_W-1:0]   d, s_nxt, m, res_nxt;
  logic [CHUNK:0]     chunk_sum;
  logic               accept;

  assign d      = {{(ACC_W-WIDTH){1'b0}}, in_data};
  assign s_nxt  = s ^ c ^ d;
  assign m      = (s & c) | (s & d) | (c & d);
  assign accept = in_valid && in_ready;

  // S and C shift right during RESOLVE, so the current chunk is always in the low bits.
  assign chunk_sum = {1'b0, s[CHUNK-1:0]} + {1'b0, c[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy};

  // Each resolved chunk enters at the top of the result register. After N cycles, chunk 0 sits at the LSB.
  assign res_nxt = ACC_W'({chunk_sum[CHUNK-1:0], res} >> CHUNK);

  assign in_ready = (state == IDLE) || (state == ACCUM);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s         <= '0;
      c         <= '0;
      res       <= '0;
      cnt       <= '0;
      cy        <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            s     <= d;
            c     <= '0;
            ovf   <= 1'b0;
            cnt   <= '0;
            cy    <= 1'b0;
            state <= in_last ? RESOLVE : ACCUM;
          end
        end
        ACCUM: begin
          if (accept) begin
            s <= s_nxt;
            c <= m << 1;
            // The carry shifted out of the top can never be cancelled by later unsigned operands.
            if (m[ACC_W-1]) ovf <= 1'b1;
            if (in_last) state <= RESOLVE;
          end
        end
        RESOLVE: begin
          s   <= s >> CHUNK;
          c   <= c >> CHUNK;
          res <= res_nxt;
          cy  <= chunk_sum[CHUNK];
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(N-1)) begin
            ovf       <= ovf | chunk_sum[CHUNK];
            out_sum   <= res_nxt;
            out_ovf   <= ovf | chunk_sum[CHUNK];
            out_valid <= 1'b1;
            cnt       <= '0;
            cy        <= 1'b0;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csa_stream_accumulator.sv
// Purpose: self-checking bench for csa_stream_accumulator. It runs directed packets plus random
//          packets against a plain-arithmetic reference (the integer sum of the operands).
// Ports:   none; instantiates the DUT with default parameters.
module tb_csa_stream_accumulator;

  localparam int WIDTH = 4;
  localparam int ACC_W = 8;
  localparam int LAT   = 4;  // ACC_W / CHUNK resolve cycles

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;
  logic             busy;

  int checks = 0;
  int errors = 0;
  int ops[$];

  csa_stream_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int total();
    int t = 0;
    foreach (ops[i]) t += ops[i];
    return t;
  endfunction

  // Drives every operand in ops. Random idle gaps carry garbage data and garbage last.
  task automatic send_ops(input int max_bubble);
    int n;
    for (int i = 0; i < ops.size(); i++) begin
      n = (max_bubble > 0) ? int'($urandom_range(0, max_bubble)) : 0;
      repeat (n) begin
        in_valid = 1'b0;
        in_data  = WIDTH'($urandom);
        in_last  = 1'($urandom);
        step();
      end
      in_valid = 1'b1;
      in_data  = WIDTH'(ops[i]);
      in_last  = (i == ops.size() - 1);
      for (int g = 0; g < 100 && !in_ready; g++) step();
      chk("accept_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = WIDTH'($urandom);
  endtask

  // Waits for out_valid, counting cycles after the last accept, then checks the result against the model.
  task automatic wait_result(input string tag);
    int lat = 0;
    int t;
    while (!out_valid && lat < 50) begin
      chk({tag, "_in_ready_resolve"}, in_ready, 0);
      chk({tag, "_busy_resolve"}, busy, 1);
      step();
      lat++;
    end
    t = total();
    chk({tag, "_out_valid"}, out_valid, 1);
    chk({tag, "_latency"}, lat, LAT);
    chk({tag, "_sum"}, out_sum, t % (1 << ACC_W));
    chk({tag, "_ovf"}, out_ovf, (t >= (1 << ACC_W)) ? 1 : 0);
    chk({tag, "_in_ready_done"}, in_ready, 0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_in_ready_back"}, in_ready, 1);
  endtask

  task automatic fill(input int val, input int n);
    ops.delete();
    repeat (n) ops.push_back(val);
  endtask

  initial begin
    logic [ACC_W-1:0] held_sum;
    logic             held_ovf;
    int               len, dly;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    step();
    step();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    step();

    ops = '{3, 5, 7, 9};
    send_ops(0);
    wait_result("p3579");
    handshake("p3579");

    ops = '{10};
    send_ops(0);
    wait_result("single_a");
    handshake("single_a");

    fill(15, 17);
    send_ops(0);
    wait_result("f_x17");
    handshake("f_x17");

    fill(15, 18);
    send_ops(0);
    wait_result("f_x18");
    handshake("f_x18");

    ops = '{1, 2, 3, 4};
    send_ops(3);
    wait_result("bubble_1234");
    handshake("bubble_1234");

    // Hold the result while out_ready stays low.
    ops = '{1, 2, 3, 4};
    send_ops(0);
    wait_result("hold_1234");
    held_sum = out_sum;
    held_ovf = out_ovf;
    repeat (6) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_sum", out_sum, held_sum);
      chk("hold_ovf", out_ovf, held_ovf);
      chk("hold_in_ready", in_ready, 0);
    end
    handshake("hold_1234");
    ops = '{15, 1};
    send_ops(0);
    wait_result("b2b_f1");
    handshake("b2b_f1");

    // Reset during the second RESOLVE cycle of an overflowing packet.
    fill(15, 18);
    send_ops(0);
    step();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_sum", out_sum, 0);
    chk("midrst_out_ovf", out_ovf, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    step();
    rst_n = 1'b1;
    step();
    ops = '{2, 2};
    send_ops(0);
    wait_result("post_rst_22");
    handshake("post_rst_22");

    // Random packets with random gaps and random output stall.
    for (int p = 0; p < 15; p++) begin
      ops.delete();
      len = int'($urandom_range(1, 40));
      repeat (len) ops.push_back(int'($urandom_range(0, (1 << WIDTH) - 1)));
      send_ops(3);
      wait_result("rand");
      dly = int'($urandom_range(0, 3));
      repeat (dly) begin
        step();
        chk("rand_stall_valid", out_valid, 1);
      end
      handshake("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
